// File: rtl/mask_ser_pkg.sv
// Shared types and defaults for the mask stream serializer.
package mask_ser_pkg;

  typedef enum logic [1:0] {
    RES_QVGA = 2'b00,
    RES_VGA  = 2'b01,
    RES_FULL = 2'b10,
    RES_RSVD = 2'b11
  } res_e;

  // Ping-pong buffer occupancy; this is the control FSM state.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } fill_e;

  localparam int unsigned DEF_MASK_W = 1080;
  localparam int unsigned DEF_OP_W   = 20;
  localparam int unsigned DEF_RES0_W = 320;
  localparam int unsigned DEF_RES1_W = 640;
  localparam int unsigned DEF_RES2_W = 1080;

  // Chunk count for a resolution; the reserved code drains as full width.
  function automatic int unsigned chunks_for(
    input res_e        sel,
    input int unsigned res0_w = DEF_RES0_W,
    input int unsigned res1_w = DEF_RES1_W,
    input int unsigned res2_w = DEF_RES2_W,
    input int unsigned op_w   = DEF_OP_W
  );
    int unsigned n;
    case (sel)
      RES_QVGA: n = res0_w / op_w;
      RES_VGA:  n = res1_w / op_w;
      default:  n = res2_w / op_w;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mask_stream_serializer_chunk_mux.sv
// Combinational chunk select: chunk idx of a row, pixel 0 at the MSB.
module mask_chunk_mux #(
  parameter int unsigned MASK_W = 1080,
  parameter int unsigned OP_W   = 20,
  parameter int unsigned IDX_W  = 6
) (
  input  logic [MASK_W-1:0] slot,
  input  logic [IDX_W-1:0]  idx,
  output logic [OP_W-1:0]   chunk_c
);

  logic [31:0]       shamt;
  logic [MASK_W-1:0] shifted;

  // Left-align the requested chunk so it always sits in the top OP_W bits.
  always_comb begin
    shamt   = 32'(idx) * 32'(OP_W);
    shifted = slot << shamt;
    chunk_c = shifted[MASK_W-1 -: OP_W];
  end

endmodule

// File: rtl/mask_stream_serializer.sv
// Two-slot ping-pong mask buffer draining rows as OP_W-bit framed chunks.
module mask_stream_serializer
  import mask_ser_pkg::*;
#(
  parameter int unsigned MASK_W = DEF_MASK_W,
  parameter int unsigned OP_W   = DEF_OP_W,
  parameter int unsigned RES0_W = DEF_RES0_W,
  parameter int unsigned RES1_W = DEF_RES1_W,
  parameter int unsigned RES2_W = DEF_RES2_W,
  parameter int unsigned IDX_W  = $clog2(RES2_W / OP_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic [MASK_W-1:0] mask_in,
  input  logic              mask_valid,
  output logic              mask_ready,
  input  logic [1:0]        res_sel,
  output logic [OP_W-1:0]   dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic [IDX_W-1:0]  dout_idx,
  output logic              err_res
);

  fill_e             state_q, state_d;
  logic [MASK_W-1:0] slot_q [2];
  res_e              sel_q  [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0]  chunk_idx_q, chunk_idx_d;
  logic              err_res_q, err_res_d;

  logic              push_c, pop_c, last_c;
  int unsigned       n_head;
  logic [OP_W-1:0]   chunk_c;

  // Handshake strobes and head framing, all decoded from registered state.
  always_comb begin
    mask_ready = (state_q != ST_FULL);
    dout_valid = (state_q != ST_EMPTY);
    n_head     = chunks_for(sel_q[rd_ptr_q], RES0_W, RES1_W, RES2_W, OP_W);
    last_c     = dout_valid && (chunk_idx_q == IDX_W'(n_head - 1));
    push_c     = mask_valid && mask_ready && clk_en;
    pop_c      = dout_valid && dout_ready && clk_en;
    dout       = dout_valid ? chunk_c : '0;
    dout_last  = last_c;
    dout_idx   = chunk_idx_q;
    err_res    = err_res_q;
  end

  mask_chunk_mux #(
    .MASK_W (MASK_W),
    .OP_W   (OP_W),
    .IDX_W  (IDX_W)
  ) u_chunk_mux (
    .slot    (slot_q[rd_ptr_q]),
    .idx     (chunk_idx_q),
    .chunk_c (chunk_c)
  );

  // Next-state: occupancy FSM, pointers, chunk index and sticky error.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    chunk_idx_d = chunk_idx_q;
    err_res_d   = err_res_q;

    case (state_q)
      ST_EMPTY: if (push_c) state_d = ST_ONE;
      ST_ONE: begin
        if (push_c && !(pop_c && last_c))      state_d = ST_FULL;
        else if (!push_c && pop_c && last_c)   state_d = ST_EMPTY;
      end
      ST_FULL:  if (pop_c && last_c) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase

    if (push_c) begin
      wr_ptr_d = ~wr_ptr_q;
      if (res_e'(res_sel) == RES_RSVD) err_res_d = 1'b1;
    end

    if (pop_c) begin
      if (last_c) begin
        chunk_idx_d = '0;
        rd_ptr_d    = ~rd_ptr_q;
      end else begin
        chunk_idx_d = chunk_idx_q + IDX_W'(1);
      end
    end
  end

  // Control registers; reset wins over the clock enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      chunk_idx_q <= '0;
      err_res_q   <= 1'b0;
    end else if (clk_en) begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      chunk_idx_q <= chunk_idx_d;
      err_res_q   <= err_res_d;
    end
  end

  // Per-slot resolution tag, cleared so an idle head decodes deterministically.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q[0] <= RES_QVGA;
      sel_q[1] <= RES_QVGA;
    end else if (push_c) begin
      sel_q[wr_ptr_q] <= res_e'(res_sel);
    end
  end

  // Slot payload storage; contents are don't-care until the slot is counted.
  always_ff @(posedge clk) begin
    if (push_c && !rst) begin
      slot_q[wr_ptr_q] <= mask_in;
    end
  end

endmodule

// File: tb/tb_mask_stream_serializer.sv
// Self-checking bench for mask_stream_serializer against a queue-based model.
module tb_mask_stream_serializer;

  localparam int MASK_W = 1080;
  localparam int OP_W   = 20;
  localparam int IDX_W  = 6;
  localparam int OBS_W  = 1 + 1 + IDX_W + OP_W + 1 + 1;

  logic              clk;
  logic              rst;
  logic              clk_en;
  logic [MASK_W-1:0] mask_in;
  logic              mask_valid;
  logic              mask_ready;
  logic [1:0]        res_sel;
  logic [OP_W-1:0]   dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_last;
  logic [IDX_W-1:0]  dout_idx;
  logic              err_res;

  mask_stream_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .mask_in    (mask_in),
    .mask_valid (mask_valid),
    .mask_ready (mask_ready),
    .res_sel    (res_sel),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .dout_idx   (dout_idx),
    .err_res    (err_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of buffered masks, head chunk position, sticky error.
  typedef struct {
    logic [MASK_W-1:0] data;
    logic [1:0]        sel;
  } mask_t;

  mask_t mq[$];
  int    m_idx     = 0;
  bit    m_err     = 1'b0;
  int    pop_count = 0;
  int    n_checks  = 0;
  int    n_fail    = 0;

  logic [OBS_W-1:0] obs;
  assign obs = {dout_valid, dout_last, dout_idx, dout, mask_ready, err_res};

  function automatic int nchunks(input logic [1:0] s);
    if (s == 2'b00) return 320 / OP_W;
    if (s == 2'b01) return 640 / OP_W;
    return 1080 / OP_W;
  endfunction

  // Pixel p lives at bit MASK_W-1-p; chunk bit OP_W-1 is the lowest pixel.
  function automatic logic [OP_W-1:0] chunk_of(input logic [MASK_W-1:0] m, input int i);
    logic [OP_W-1:0] c;
    for (int b = 0; b < OP_W; b++) c[OP_W-1-b] = m[MASK_W-1-(i*OP_W+b)];
    return c;
  endfunction

  function automatic logic [OBS_W-1:0] model_obs();
    logic [OBS_W-1:0] e;
    if (mq.size() == 0)
      e = {1'b0, 1'b0, IDX_W'(0), OP_W'(0), 1'b1, m_err};
    else
      e = {1'b1, (m_idx == nchunks(mq[0].sel) - 1), IDX_W'(m_idx),
           chunk_of(mq[0].data, m_idx), (mq.size() < 2), m_err};
    return e;
  endfunction

  function automatic logic [MASK_W-1:0] rand_mask();
    logic [MASK_W-1:0] m;
    logic [31:0]       r;
    r = 32'h0;
    for (int i = 0; i < MASK_W; i++) begin
      if (i % 32 == 0) r = $urandom;
      m[i] = r[i % 32];
    end
    return m;
  endfunction

  // Advance one clock and apply the same edge to the model.
  task automatic step();
    bit    do_push, do_pop;
    mask_t nm;
    do_pop  = clk_en && dout_ready && (mq.size() > 0);
    do_push = clk_en && mask_valid && (mq.size() < 2);
    nm.data = mask_in;
    nm.sel  = res_sel;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_idx = 0;
      m_err = 1'b0;
    end else begin
      if (do_pop) begin
        pop_count++;
        if (m_idx == nchunks(mq[0].sel) - 1) begin
          mq.delete(0);
          m_idx = 0;
        end else begin
          m_idx++;
        end
      end
      if (do_push) begin
        mq.push_back(nm);
        if (nm.sel == 2'b11) m_err = 1'b1;
      end
    end
    #1;
  endtask

  task automatic push_mask(input logic [MASK_W-1:0] d, input logic [1:0] s);
    mask_in    = d;
    res_sel    = s;
    mask_valid = 1'b1;
    step();
    mask_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clk_en = 1'b1; mask_valid = 1'b0; dout_ready = 1'b0;
    mask_in = '0; res_sel = 2'b00;
    step(); step();
    rst = 1'b0;
    n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", dout_valid); end
    n_checks++; if (mask_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", mask_ready); end
    n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL reset_dout got %h exp 0", dout); end
    n_checks++; if (dout_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b exp 0", dout_last); end
    n_checks++; if (dout_idx !== '0) begin n_fail++; $display("FAIL reset_idx got %0d exp 0", dout_idx); end
    n_checks++; if (err_res !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err_res); end
  endtask

  task automatic test_single_640();
    logic [MASK_W-1:0] d;
    logic [OP_W-1:0]   exp_c;
    d = '0;
    for (int p = 0; p < 20; p++) d[MASK_W-1-p] = 1'b1;
    for (int p = 640; p < MASK_W; p++) d[MASK_W-1-p] = 1'($urandom % 2);
    dout_ready = 1'b1;
    push_mask(d, 2'b01);
    for (int i = 0; i < 32; i++) begin
      exp_c = (i == 0) ? 20'hFFFFF : 20'h0;
      n_checks++; if (dout !== exp_c) begin n_fail++; $display("FAIL single_dout i=%0d got %h exp %h", i, dout, exp_c); end
      n_checks++; if (dout_last !== (i == 31)) begin n_fail++; $display("FAIL single_last i=%0d got %b", i, dout_last); end
      n_checks++; if (mask_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready i=%0d got %b exp 1", i, mask_ready); end
      n_checks++; if (obs !== model_obs()) begin n_fail++; $display("FAIL single_obs i=%0d got %h exp %h", i, obs, model_obs()); end
      step();
    end
    n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL single_end got %b exp 0", dout_valid); end
  endtask

  task automatic test_back_to_back();
    dout_ready = 1'b0;
    push_mask(rand_mask(), 2'b00);
    push_mask(rand_mask(), 2'b10);
    n_checks++; if (mask_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready got %b exp 0", mask_ready); end
    n_checks++; if (obs !== model_obs()) begin n_fail++; $display("FAIL b2b_full_obs got %h exp %h", obs, model_obs()); end
    dout_ready = 1'b1;
    for (int i = 0; i < 70; i++) begin
      n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_gap i=%0d got %b exp 1", i, dout_valid); end
      n_checks++; if (obs !== model_obs()) begin n_fail++; $display("FAIL b2b_obs i=%0d got %h exp %h", i, obs, model_obs()); end
      if (i == 69) begin
        mask_in = rand_mask(); res_sel = 2'($urandom_range(0, 2)); mask_valid = 1'b1;
      end
      step();
      mask_valid = 1'b0;
    end
    for (int i = 0; i < 60 && mq.size() > 0; i++) begin
      n_checks++; if (obs !== model_obs()) begin n_fail++; $display("FAIL b2b_tail i=%0d got %h exp %h", i, obs, model_obs()); end
      step();
    end
    n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end got %b exp 0", dout_valid); end
  endtask

  task automatic test_stall_random();
    int start;
    push_mask(rand_mask(), 2'b00);
    start = pop_count;
    for (int c = 0; c < 300 && mq.size() > 0; c++) begin
      dout_ready = 1'($urandom % 2);
      n_checks++; if (obs !== model_obs()) begin n_fail++; $display("FAIL stall_obs c=%0d got %h exp %h", c, obs, model_obs()); end
      step();
    end
    n_checks++; if (pop_count - start !== 16) begin n_fail++; $display("FAIL stall_pops got %0d exp 16", pop_count - start); end
    n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL stall_end got %b exp 0", dout_valid); end
  endtask

  task automatic test_clk_en();
    dout_ready = 1'b1;
    push_mask(rand_mask(), 2'b01);
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (obs !== model_obs()) begin n_fail++; $display("FAIL cen_pre i=%0d got %h exp %h", i, obs, model_obs()); end
      step();
    end
    clk_en = 1'b0;
    mask_in = rand_mask(); res_sel = 2'b11; mask_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++; if (dout_idx !== 6'd10) begin n_fail++; $display("FAIL cen_idx i=%0d got %0d exp 10", i, dout_idx); end
      n_checks++; if (obs !== model_obs()) begin n_fail++; $display("FAIL cen_hold i=%0d got %h exp %h", i, obs, model_obs()); end
    end
    mask_valid = 1'b0; clk_en = 1'b1;
    for (int i = 0; i < 40 && mq.size() > 0; i++) begin
      n_checks++; if (obs !== model_obs()) begin n_fail++; $display("FAIL cen_post i=%0d got %h exp %h", i, obs, model_obs()); end
      step();
    end
  endtask

  task automatic test_reset_mid();
    dout_ready = 1'b0;
    push_mask(rand_mask(), 2'b11);
    push_mask(rand_mask(), 2'b10);
    dout_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      n_checks++; if (obs !== model_obs()) begin n_fail++; $display("FAIL rmid_obs i=%0d got %h exp %h", i, obs, model_obs()); end
      step();
    end
    n_checks++; if (dout_idx !== 6'd7) begin n_fail++; $display("FAIL rmid_idx got %0d exp 7", dout_idx); end
    n_checks++; if (err_res !== 1'b1) begin n_fail++; $display("FAIL rmid_err_pre got %b exp 1", err_res); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b exp 0", dout_valid); end
    n_checks++; if (mask_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready got %b exp 1", mask_ready); end
    n_checks++; if (err_res !== 1'b0) begin n_fail++; $display("FAIL rmid_err got %b exp 0", err_res); end
    push_mask(rand_mask(), 2'b00);
    n_checks++; if (dout_idx !== 6'd0) begin n_fail++; $display("FAIL rmid_restart got %0d exp 0", dout_idx); end
    for (int i = 0; i < 20 && mq.size() > 0; i++) begin
      n_checks++; if (obs !== model_obs()) begin n_fail++; $display("FAIL rmid_new i=%0d got %h exp %h", i, obs, model_obs()); end
      step();
    end
    n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_end got %b exp 0", dout_valid); end
  endtask

  task automatic test_rsvd();
    dout_ready = 1'b1;
    push_mask(rand_mask(), 2'b11);
    for (int i = 0; i < 54; i++) begin
      n_checks++; if (err_res !== 1'b1) begin n_fail++; $display("FAIL rsvd_err i=%0d got %b exp 1", i, err_res); end
      n_checks++; if (dout_last !== (i == 53)) begin n_fail++; $display("FAIL rsvd_last i=%0d got %b", i, dout_last); end
      n_checks++; if (obs !== model_obs()) begin n_fail++; $display("FAIL rsvd_obs i=%0d got %h exp %h", i, obs, model_obs()); end
      step();
    end
    n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL rsvd_end got %b exp 0", dout_valid); end
    n_checks++; if (err_res !== 1'b1) begin n_fail++; $display("FAIL rsvd_sticky got %b exp 1", err_res); end
  endtask

  task automatic test_random_traffic();
    rst = 1'b1; step(); rst = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      mask_valid = ($urandom % 3) != 0;
      mask_in    = rand_mask();
      res_sel    = 2'($urandom % 4);
      dout_ready = ($urandom % 4) != 0;
      clk_en     = ($urandom % 8) != 0;
      n_checks++; if (obs !== model_obs()) begin n_fail++; $display("FAIL random_obs c=%0d got %h exp %h", c, obs, model_obs()); end
      step();
    end
    mask_valid = 1'b0; clk_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_640();
    test_back_to_back();
    test_stall_random();
    test_clk_en();
    test_reset_mid();
    test_rsvd();
    test_random_traffic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mask_stream_serializer.md
Name: mask_stream_serializer

Overview:
- Parametrised successor to the mask-generator serializer path; sits between the mask generator and the mask output channel.
- Accepts full-row masks through a valid/ready handshake into a two-slot ping-pong buffer.
- Emits each mask as OP_W-bit chunks with valid/ready/last framing.
- Chunk count per mask is selected at runtime per mask: 320, 640 or 1080 pixels by default. The generator can load mask N+1 while mask N drains, with no drops.

Parameters:
- MASK_W, 1080: input mask width in pixels; must be ≥ RES2_W.
- OP_W, 20: output chunk width; RES0_W, RES1_W and RES2_W must each be divisible by OP_W.
- RES0_W, 320: active pixels for res_sel 00.
- RES1_W, 640: active pixels for res_sel 01.
- RES2_W, 1080: active pixels for res_sel 10.
- IDX_W, $clog2(RES2_W/OP_W): width of the chunk index.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- clk_en  in  1  clock enable; when low, all state is frozen.
- mask_in  in  MASK_W  mask row; pixel 0 at bit MASK_W-1.
- mask_valid  in  1  mask_in and res_sel are valid.
- mask_ready  out  1  a buffer slot is free.
- res_sel  in  2  resolution of this mask, captured with it.
- dout  out  OP_W  chunk; lowest-numbered pixel of the chunk at bit OP_W-1.
- dout_valid  out  1  dout is valid.
- dout_ready  in  1  downstream accepts the chunk.
- dout_last  out  1  dout is the final chunk of the current mask.
- dout_idx  out  IDX_W  chunk number within the current mask.
- err_res  out  1  sticky flag: res_sel 11 was accepted.

Behaviour:
- Reset (rst high at a clk edge, regardless of clk_en):
  - count=0, wr_ptr=0, rd_ptr=0, chunk_idx=0, err_res=0.
  - Outputs: mask_ready=1, dout_valid=0, dout=0, dout_last=0, dout_idx=0.
  - Reset mid-mask discards both slots; no partial chunk is emitted afterwards.
- State advances only on edges where clk_en=1. With clk_en=0, all registers hold and all outputs stay stable.
- Push: mask_valid & mask_ready & clk_en.
  - Write mask_in into slot[wr_ptr] and store res_sel alongside it.
  - wr_ptr toggles; count increments.
- mask_ready = (count < 2). It is registered-state derived only: no same-cycle bypass from a pop.
- Output head:
  - dout_valid = (count > 0).
  - dout = slot[rd_ptr] bits [MASK_W-1-chunk_idx*OP_W -: OP_W] when valid, else 0.
  - dout_idx = chunk_idx.
- Chunks per mask, N(sel): 00→RES0_W/OP_W, 01→RES1_W/OP_W, 10→RES2_W/OP_W, 11→RES2_W/OP_W and sets err_res=1 at the push.
- dout_last = dout_valid & (chunk_idx == N(head_sel)-1).
- Pop step: dout_valid & dout_ready & clk_en.
  - If not last: chunk_idx increments.
  - If last: chunk_idx←0, rd_ptr toggles, count decrements.
- Push and last-chunk pop on the same edge: both take effect, count is unchanged.
  - This is only possible at count=1, since mask_ready=0 at count=2.
- Latency: a mask pushed into an empty buffer at edge E gives dout_valid=1 with chunk 0 in the cycle after E.
- Throughput:
  - One chunk per cycle while dout_ready=1.
  - Back-to-back masks drain with no bubble: the chunk 0 of the next slot follows the last chunk of the previous one immediately.
- dout_valid, once asserted, holds until the pop step; dout is stable while dout_ready=0.
- Pixels beyond the active resolution in mask_in are ignored.

Decomposition:
- Package mask_ser_pkg:
  - res_e enum: RES_QVGA=2'b00, RES_VGA=2'b01, RES_FULL=2'b10, RES_RSVD=2'b11.
  - Default constants for RES0_W, RES1_W, RES2_W and OP_W.
  - Function chunks_for(res_e) returning the chunk count.
- Sub-module mask_chunk_mux: a combinational chunk select from one slot by index. Keeps the MASK_W-wide mux out of the control FSM.

Test Plan:
1. Push one 640-px mask with pixels 0..19 = 1, rest 0, res_sel=01, OP_W=20, dout_ready=1. Expect: 32 chunks; chunk 0 = 0xFFFFF, chunks 1–31 = 0; dout_last only on idx 31; mask_ready stays 1.
2. Push masks A (res 00) and B (res 10) back-to-back, dout_ready=0. Expect: mask_ready drops after the second push. Then hold dout_ready=1: expect 16 chunks of A, then 54 chunks of B, with no gap between them.
3. Toggle dout_ready randomly during a 320-px mask. Expect: dout stable while stalled; the chunk sequence is identical to scenario 1's ordering; exactly 16 pops.
4. Hold clk_en=0 for 5 cycles mid-mask. Expect: chunk_idx, dout and counters unchanged; the stream resumes at the same index once clk_en=1.
5. Assert rst at chunk idx 7 with both slots full. Expect: dout_valid=0, mask_ready=1 and err_res=0 in the next cycle. A new mask then starts at idx 0.
6. Push with res_sel=11. Expect: err_res=1 permanently until rst; mask drains as 54 chunks.
